// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter width; a single-digit adder still keeps a 1-bit counter.
  function automatic int cnt_width(input int n_digits);
    return (n_digits <= 1) ? 1 : $clog2(n_digits);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result bus of the digit-serial adder; the sub signal exists only
// when DIGIT_SERIAL_ADDER_SUB_EN is defined.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  // Both channels are valid/ready: a transfer happens on a rising clk edge
  // where valid and ready are both high; the sender holds its data stable
  // while valid is high and not yet accepted.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );
  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
`else
  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );
  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
`endif

endinterface

// File: rtl/digit_serial_adder_wholeass.sv
// wholeass: 1-bit full adder cell used to build the per-cycle ripple chain.
module wholeass (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add over WIDTH/DIGIT cycles, DIGIT bits per
// cycle. Define DIGIT_SERIAL_ADDER_SUB_EN to add the subtract-mode sub input.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  digit_serial_adder_if.slave        bus,
  output state_e                     o_state
);

  localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1) begin : g_bad_range
      $error("digit_serial_adder: WIDTH and DIGIT must both be >= 1");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_div
      $error("digit_serial_adder: DIGIT must divide WIDTH");
    end
  endgenerate

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_dsum;
  logic             w_sub_in;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign w_sub_in = bus.sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign w_c[0] = r_carry;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_chain
      wholeass u_fa (
        .i_a    (r_a[i]),
        .i_b    (r_b[i]),
        .i_cin  (w_c[i]),
        .o_s    (w_dsum[i]),
        .o_cout (w_c[i+1])
      );
    end
  endgenerate

  // Subtraction is a + ~b + ~cin; carry_out then reports borrow (inverted raw
  // carry) while overflow keeps using the raw carries into/out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= w_sub_in ? ~bus.b : bus.b;
            r_carry <= bus.carry_in ^ w_sub_in;
            r_sub   <= w_sub_in;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= WIDTH'({w_dsum, r_sum} >> DIGIT);
          r_carry <= w_c[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout  <= w_c[DIGIT] ^ r_sub;
            r_ovf   <= w_c[DIGIT-1] ^ w_c[DIGIT];
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;
  assign o_state       = r_state;

endmodule
